pbvi_backup_argmax: RTL and testbench
=====================================

# pbvi_backup_argmax

Parametrised, time-multiplexed PBVI backup stage. For each belief point it scans every candidate alpha vector of every (action, observation) pair, keeps the running argmax of the fixed-point dot product, then forms the per-action backed-up vector: reward plus the selected alpha of each observation. It sits between the intermediate-alpha generator and the best-action selector. It streams one result per belief point over a valid/ready handshake, with saturating arithmetic.

## Interface
- N_ACT, 3, number of actions
- N_OBS, 2, number of observations
- N_ALPHA, 16, candidate alpha vectors per (action, observation); ≥2
- N_BELIEF, 16, belief points per run; ≥1
- N_STATE, 2, POMDP states (vector length)
- W, 16, data width; values are unsigned Q0.W
- IW = $clog2(N_ALPHA), BW = $clog2(N_BELIEF) (derived localparams)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- alpha  in  N_ACT*N_OBS*N_ALPHA*N_STATE*W  flattened, index ((a*N_OBS+o)*N_ALPHA+j)*N_STATE+s
- reward  in  N_ACT*N_STATE*W  flattened, index a*N_STATE+s
- belief  in  N_BELIEF*N_STATE*W  flattened, index b*N_STATE+s
- busy  out  1  high from the cycle after start is accepted until done
- out_valid  out  1  result for belief out_belief_idx is valid
- out_ready  in  1  consumer accepts the result
- out_belief_idx  out  BW  belief point of the current result
- out_gamma  out  N_ACT*N_STATE*W  backed-up vectors, index a*N_STATE+s
- out_alpha_idx  out  N_ACT*N_OBS*IW  selected alpha per (a,o), index a*N_OBS+o
- done  out  1  one-cycle pulse after the last result transfers

## Operation
- FSM states: IDLE, SCAN, SUM, EMIT, DONE.
- IDLE → SCAN on start; belief counter b=0, alpha counter j=0.
- SCAN: one alpha index j per cycle. All N_ACT*N_OBS lanes run in parallel.
  - Each lane computes dot = sat_W((Σ_s alpha[a][o][j][s]*belief[b][s]) >> W).
  - The accumulator is 2W+$clog2(N_STATE) bits wide, so it cannot overflow before the shift.
  - best/best_idx load when j==0 or dot > best (strict compare). Ties keep the lowest index.
  - After j==N_ALPHA-1 the FSM goes to SUM.
- SUM (1 cycle): gamma[a][s] = sat_W(reward[a][s] + Σ_o alpha[a][o][best_idx[a][o]][s]). This registers out_gamma, out_alpha_idx and out_belief_idx=b, then goes to EMIT.
- EMIT: out_valid=1. Outputs stay frozen until out_valid && out_ready.
  - On transfer with b<N_BELIEF-1: b++, j=0, go to SCAN.
  - On transfer with b==N_BELIEF-1: go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start is ignored outside IDLE. alpha, reward and belief must be held stable from start acceptance to done; changing them mid-run gives undefined results. No hazard logic is provided for this.
- Saturation: any intermediate or final result ≥ 2^W clamps to 2^W-1. There is no wrap.

## Timing
- Reset values: busy=0, out_valid=0, done=0, out_gamma=0, out_alpha_idx=0, out_belief_idx=0. FSM resets to IDLE.
- Reset asserted mid-run aborts the run immediately. No done pulse is produced.
- start high in cycle 0 gives:
  - busy=1 from cycle 1
  - SCAN in cycles 1..N_ALPHA
  - SUM in cycle N_ALPHA+1
  - out_valid=1 from cycle N_ALPHA+2
- Per belief point: N_ALPHA+2 cycles with out_ready=1, plus one cycle per stall cycle.
- With out_ready tied high, done pulses in cycle N_BELIEF*(N_ALPHA+2)+1, and busy falls in that same cycle.
- out_valid drops the cycle after transfer and stays low during SCAN/SUM. It never re-asserts for the same b.
- out_ready while out_valid=0 has no effect.
- start high in the DONE cycle is ignored. A new run needs start in IDLE.

## Test plan
- Single hot alpha, default params, every b: belief=(0xFFFF,0), all alphas 0 except j=5=(0x2000,0x2000), reward=(0x0100,0x0100) → out_alpha_idx=5 on all lanes, out_gamma all 0x4100, first out_valid at cycle 18.
- Tie break: all alphas equal 0x1234, any belief → every out_alpha_idx=0; gamma=reward+2*0x1234.
- Saturation: all alphas (0xFFFF,0xFFFF), belief (0xFFFF,0xFFFF), reward 0xFFFF → dot clamps to 0xFFFF, out_gamma=0xFFFF (no wrap), out_alpha_idx=0.
- Backpressure: out_ready low for 5 cycles at b=3 → out_valid held, out_gamma/out_belief_idx stable; b=4 starts only after the handshake; total run = 16*18+5 cycles.
- Throughput and done: out_ready=1, ramp alphas j*0x0800 per state, belief (0x8000,0x8000) → idx 15 on every result, exactly 16 transfers with out_belief_idx 0..15 in order, done single pulse at cycle 289, start during busy ignored.
- Reset mid-SCAN at cycle 40 → all outputs 0 next cycle, no done; a fresh start reproduces the first test exactly.

Source files
------------

// File: rtl/pbvi_backup_argmax.sv
// pbvi_backup_argmax: time-multiplexed PBVI backup with a running argmax over alpha vectors
// ports: clk, rst_n (async, active-low); start launches a run over every belief point;
//   alpha/reward/belief are flattened inputs that stay stable for the whole run; busy is high while running;
//   out_valid/out_ready hand over out_belief_idx, out_gamma, out_alpha_idx; done pulses after the last transfer
module pbvi_backup_argmax #(
  parameter int N_ACT = 3,
  parameter int N_OBS = 2,
  parameter int N_ALPHA = 16,
  parameter int N_BELIEF = 16,
  parameter int N_STATE = 2,
  parameter int W = 16,
  localparam int IW = $clog2(N_ALPHA),
  localparam int BW = N_BELIEF > 1 ? $clog2(N_BELIEF) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [N_ACT*N_OBS*N_ALPHA*N_STATE*W-1:0] alpha,
  input  logic [N_ACT*N_STATE*W-1:0]        reward,
  input  logic [N_BELIEF*N_STATE*W-1:0]     belief,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BW-1:0]                     out_belief_idx,
  output logic [N_ACT*N_STATE*W-1:0]        out_gamma,
  output logic [N_ACT*N_OBS*IW-1:0]         out_alpha_idx,
  output logic                              done
);
  localparam int NL = N_ACT * N_OBS;
  localparam int AW = 2 * W + $clog2(N_STATE);
  localparam int GW = W + $clog2(N_OBS + 1);
  typedef enum logic [2:0] {IDLE, SCAN, SUM, EMIT, DONE} state_t;
  state_t state, next;
  logic [IW-1:0] j;
  logic [BW-1:0] b;
  logic [W-1:0] best [NL];
  logic [IW-1:0] best_idx [NL];
  logic [W-1:0] dot [NL];
  logic [AW-1:0] acc;
  logic [GW-1:0] gsum;
  logic [N_ACT*N_STATE*W-1:0] gamma_next;
  assign busy = state == SCAN || state == SUM || state == EMIT;
  assign out_valid = state == EMIT;
  assign done = state == DONE;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? SCAN : IDLE;
      SCAN: next = j == IW'(N_ALPHA - 1) ? SUM : SCAN;
      SUM: next = EMIT;
      EMIT: next = !out_ready ? EMIT : b == BW'(N_BELIEF - 1) ? DONE : SCAN;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // every lane scores candidate j against belief b; >>W keeps the Q0.W scale, then clamp
  always_comb begin
    acc = '0;
    for (int l = 0; l < NL; l++) begin
      acc = '0;
      for (int s = 0; s < N_STATE; s++)
        acc = acc + AW'(alpha[((l * N_ALPHA + int'(j)) * N_STATE + s) * W +: W])
                  * AW'(belief[(int'(b) * N_STATE + s) * W +: W]);
      dot[l] = (acc >> W) > AW'({W{1'b1}}) ? {W{1'b1}} : acc[2*W-1:W];
    end
  end
  always_comb begin
    gsum = '0;
    gamma_next = '0;
    for (int a = 0; a < N_ACT; a++)
      for (int s = 0; s < N_STATE; s++) begin
        gsum = GW'(reward[(a * N_STATE + s) * W +: W]);
        for (int o = 0; o < N_OBS; o++)
          gsum = gsum + GW'(alpha[(((a * N_OBS + o) * N_ALPHA + int'(best_idx[a * N_OBS + o])) * N_STATE + s) * W +: W]);
        gamma_next[(a * N_STATE + s) * W +: W] = gsum > GW'({W{1'b1}}) ? {W{1'b1}} : gsum[W-1:0];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      j <= '0;
      b <= '0;
      out_gamma <= '0;
      out_alpha_idx <= '0;
      out_belief_idx <= '0;
      for (int l = 0; l < NL; l++) begin
        best[l] <= '0;
        best_idx[l] <= '0;
      end
    end else begin
      state <= next;
      if (state == IDLE) begin
        j <= '0;
        b <= '0;
      end else if (state == SCAN)
        j <= j == IW'(N_ALPHA - 1) ? '0 : j + 1'b1;
      else if (state == EMIT && out_ready) begin
        j <= '0;
        b <= b + 1'b1;
      end
      // strict compare keeps the lowest index on ties
      for (int l = 0; l < NL; l++)
        if (state == SCAN && (j == '0 || dot[l] > best[l])) begin
          best[l] <= dot[l];
          best_idx[l] <= j;
        end
      if (state == SUM) begin
        out_gamma <= gamma_next;
        out_belief_idx <= b;
        for (int l = 0; l < NL; l++) out_alpha_idx[l*IW +: IW] <= best_idx[l];
      end
    end
endmodule

// File: tb/tb_pbvi_backup_argmax.sv
// tb_pbvi_backup_argmax: table-driven check of pbvi_backup_argmax with directed corner sequences
module tb_pbvi_backup_argmax;
  localparam int NA = 3, NO = 2, NJ = 16, NB = 16, NS = 2, W = 16, NL = 6;
  typedef struct {
    int kind;
    logic [15:0] b0, b1, r0, r1;
    logic [5:0][3:0] idx;
    logic [2:0][15:0] g0, g1;
  } vec_t;
  logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
  logic [NL*NJ*NS*W-1:0] alpha = '0;
  logic [NA*NS*W-1:0] reward = '0;
  logic [NB*NS*W-1:0] belief = '0;
  logic busy, out_valid, done;
  logic [3:0] out_belief_idx;
  logic [NA*NS*W-1:0] out_gamma;
  logic [NL*4-1:0] out_alpha_idx;
  int checks = 0, errors = 0, cyc = 0;
  vec_t vt [7];
  pbvi_backup_argmax dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alpha(alpha), .reward(reward), .belief(belief),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_belief_idx(out_belief_idx),
    .out_gamma(out_gamma), .out_alpha_idx(out_alpha_idx), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 128'(busy), 128'(0));
    chk({nm, "_valid"}, 128'(out_valid), 128'(0));
    chk({nm, "_done"}, 128'(done), 128'(0));
    chk({nm, "_gamma"}, 128'(out_gamma), 128'(0));
    chk({nm, "_aidx"}, 128'(out_alpha_idx), 128'(0));
    chk({nm, "_bidx"}, 128'(out_belief_idx), 128'(0));
  endtask
  task automatic load(input vec_t v);
    for (int l = 0; l < NL; l++)
      for (int j = 0; j < NJ; j++)
        for (int s = 0; s < NS; s++) begin
          logic [15:0] x;
          case (v.kind)
            0: x = j == 5 ? 16'h2000 : 16'h0000;
            1: x = 16'h1234;
            2: x = 16'hFFFF;
            3: x = 16'(j * 'h800);
            4: x = j != l + 1 ? 16'h0000 : s == 0 ? 16'((l + 1) * 'h400) : 16'h0100;
            default: x = 16'((15 - j) * 'h800);
          endcase
          alpha[((l * NJ + j) * NS + s) * W +: W] = x;
        end
    for (int a = 0; a < NA; a++) begin
      reward[(a * NS) * W +: W] = v.r0;
      reward[(a * NS + 1) * W +: W] = v.r1;
    end
    for (int b = 0; b < NB; b++) begin
      belief[(b * NS) * W +: W] = v.b0;
      belief[(b * NS + 1) * W +: W] = v.b1;
    end
  endtask
  task automatic run(input vec_t v, input int stall_b, input int stall_n, input bit hold_start);
    logic [NA*NS*W-1:0] eg;
    logic [NL*4-1:0] ei;
    int n, stall;
    for (int l = 0; l < NL; l++) ei[l*4 +: 4] = v.idx[l];
    for (int a = 0; a < NA; a++) begin
      eg[(a * NS) * W +: W] = v.g0[a];
      eg[(a * NS + 1) * W +: W] = v.g1[a];
    end
    load(v);
    out_ready = 1;
    cyc = 0;
    start = 1;
    tick;
    if (!hold_start) start = 0;
    chk("busy_c1", 128'(busy), 128'(1));
    stall = 0;
    for (int b = 0; b < NB; b++) begin
      n = 0;
      while (!out_valid && n < 60) begin
        tick;
        n++;
      end
      chk("valid", 128'(out_valid), 128'(1));
      chk("valid_cycle", 128'(cyc), 128'(18 + 18 * b + stall));
      chk("bidx", 128'(out_belief_idx), 128'(b));
      chk("aidx", 128'(out_alpha_idx), 128'(ei));
      chk("gamma", 128'(out_gamma), 128'(eg));
      if (b == stall_b) begin
        out_ready = 0;
        for (int k = 0; k < stall_n; k++) begin
          tick;
          chk("stall_valid", 128'(out_valid), 128'(1));
          chk("stall_bidx", 128'(out_belief_idx), 128'(b));
          chk("stall_gamma", 128'(out_gamma), 128'(eg));
        end
        out_ready = 1;
        stall = stall_n;
      end
      tick;
      if (b < NB - 1) chk("valid_drop", 128'(out_valid), 128'(0));
    end
    chk("done", 128'(done), 128'(1));
    chk("busy_done", 128'(busy), 128'(0));
    chk("done_cycle", 128'(cyc), 128'(NB * 18 + 1 + stall));
    tick;
    start = 0;
    chk("done_pulse", 128'(done), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    tick;
    chk("idle_busy2", 128'(busy), 128'(0));
  endtask
  initial begin
    vt[0] = '{kind: 0, b0: 16'hFFFF, b1: 16'h0000, r0: 16'h0100, r1: 16'h0100,
              idx: {6{4'd5}}, g0: {3{16'h4100}}, g1: {3{16'h4100}}};
    vt[1] = '{kind: 1, b0: 16'h8000, b1: 16'h4000, r0: 16'h0100, r1: 16'h0200,
              idx: {6{4'd0}}, g0: {3{16'h2568}}, g1: {3{16'h2668}}};
    vt[2] = '{kind: 2, b0: 16'hFFFF, b1: 16'hFFFF, r0: 16'hFFFF, r1: 16'hFFFF,
              idx: {6{4'd0}}, g0: {3{16'hFFFF}}, g1: {3{16'hFFFF}}};
    vt[3] = '{kind: 3, b0: 16'h8000, b1: 16'h8000, r0: 16'h0100, r1: 16'h0100,
              idx: {6{4'd15}}, g0: {3{16'hF100}}, g1: {3{16'hF100}}};
    vt[4] = '{kind: 3, b0: 16'h8000, b1: 16'h8000, r0: 16'h0FFF, r1: 16'h1000,
              idx: {6{4'd15}}, g0: {3{16'hFFFF}}, g1: {3{16'hFFFF}}};
    vt[5] = '{kind: 4, b0: 16'h8000, b1: 16'h8000, r0: 16'h0010, r1: 16'h0020,
              idx: {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1},
              g0: {16'h2C10, 16'h1C10, 16'h0C10}, g1: {3{16'h0220}}};
    vt[6] = '{kind: 5, b0: 16'h8000, b1: 16'h8000, r0: 16'h0000, r1: 16'h0000,
              idx: {6{4'd0}}, g0: {3{16'hF000}}, g1: {3{16'hF000}}};
    repeat (2) tick;
    chk_zero("reset");
    rst_n = 1;
    tick;
    for (int v = 0; v < 7; v++) run(vt[v], -1, 0, 1'b0);
    run(vt[0], 3, 5, 1'b1);
    load(vt[0]);
    cyc = 0;
    start = 1;
    tick;
    start = 0;
    repeat (39) tick;
    chk("pre_abort_busy", 128'(busy), 128'(1));
    rst_n = 0;
    #1;
    chk_zero("abort");
    repeat (3) begin
      tick;
      chk("abort_done", 128'(done), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
    end
    rst_n = 1;
    tick;
    run(vt[0], -1, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
